// File: rtl/sda_gmem_read_arbiter.sv
// Two-requester arbiter for the kernel gmem AXI4 read channel (AR + R).
// Grants are recorded in a route FIFO that steers the in-order R bursts back.

module sda_gmem_rd_lane #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  ar_win,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic                  r_sel,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  input  logic                  s_rready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  output logic                  r_ready
);
  assign s_arready = ar_win & s_arvalid;
  // Payload is broadcast; only rvalid tells the lane the beat is its own.
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;
  assign s_rvalid  = r_sel & m_rvalid;
  assign r_ready   = r_sel & s_rready;
endmodule

module sda_gmem_read_arbiter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready
);
  localparam int NUM_LANES = 2;
  localparam int PW        = $clog2(MAX_OUTSTANDING);
  localparam int CW        = PW + 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  logic [NUM_LANES-1:0]                 s_arvalid, s_arready, s_rready, s_rvalid, s_rlast;
  logic [NUM_LANES-1:0]                 ar_win, r_sel, lane_rready;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] s_araddr;
  logic [NUM_LANES-1:0][7:0]            s_arlen;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] s_rdata;
  logic [NUM_LANES-1:0][1:0]            s_rresp;

  state_e                   state_q, state_d;
  logic                     prio_q, prio_d;
  logic                     gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]    araddr_q, araddr_d;
  logic [7:0]               arlen_q, arlen_d;
  logic [MAX_OUTSTANDING-1:0] route_q, route_d;
  logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;

  logic win, can_grant, grant, push, pop, empty, head;

  assign s_arvalid   = {s1_arvalid, s0_arvalid};
  assign s_rready    = {s1_rready, s0_rready};
  assign s_araddr[0] = s0_araddr;
  assign s_araddr[1] = s1_araddr;
  assign s_arlen[0]  = s0_arlen;
  assign s_arlen[1]  = s1_arlen;

  assign s0_arready = s_arready[0];
  assign s1_arready = s_arready[1];
  assign s0_rdata   = s_rdata[0];
  assign s1_rdata   = s_rdata[1];
  assign s0_rresp   = s_rresp[0];
  assign s1_rresp   = s_rresp[1];
  assign s0_rlast   = s_rlast[0];
  assign s1_rlast   = s_rlast[1];
  assign s0_rvalid  = s_rvalid[0];
  assign s1_rvalid  = s_rvalid[1];

  // Pointer owner wins if it is asking; otherwise the other requester.
  assign win       = s_arvalid[prio_q] ? prio_q : ~prio_q;
  assign can_grant = (state_q == IDLE) && (cnt_q < CW'(MAX_OUTSTANDING));
  assign grant     = |s_arready;
  assign empty     = (cnt_q == '0);
  assign head      = route_q[rptr_q];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign ar_win[i] = can_grant & (win == 1'(i));
    assign r_sel[i]  = ~empty & (head == 1'(i));

    sda_gmem_rd_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .ar_win   (ar_win[i]),
      .s_arvalid(s_arvalid[i]),
      .s_arready(s_arready[i]),
      .r_sel    (r_sel[i]),
      .m_rdata  (m_rdata),
      .m_rresp  (m_rresp),
      .m_rlast  (m_rlast),
      .m_rvalid (m_rvalid),
      .s_rready (s_rready[i]),
      .s_rdata  (s_rdata[i]),
      .s_rresp  (s_rresp[i]),
      .s_rlast  (s_rlast[i]),
      .s_rvalid (s_rvalid[i]),
      .r_ready  (lane_rready[i])
    );
  end

  assign m_rready  = |lane_rready;
  assign m_arvalid = (state_q == ISSUE);
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign pop       = ~empty & m_rvalid & m_rready & m_rlast;

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    gnt_d    = gnt_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          araddr_d = s_araddr[win];
          arlen_d  = s_arlen[win];
          gnt_d    = win;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (m_arready) begin
          push    = 1'b1;
          prio_d  = ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Route FIFO; a push can never hit a full FIFO because grants check count first.
  always_comb begin
    route_d = route_q;
    if (push) route_d[wptr_q] = gnt_q;
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      gnt_q    <= 1'b0;
      araddr_q <= '0;
      arlen_q  <= '0;
      route_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      gnt_q    <= gnt_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      route_q  <= route_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_sda_gmem_read_arbiter.sv
// Randomized scoreboard bench: requester/gmem models feed expected AR and R
// traffic into queues; a negedge monitor compares every DUT output against them.
module tb_sda_gmem_read_arbiter;
  localparam int AW = 64, DW = 64, MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][AW-1:0] s_araddr = '0;
  logic [1:0][7:0]    s_arlen = '0;
  logic [1:0]         s_arvalid = '0, s_rready = 2'b11;
  logic [1:0]         s_arready, s_rvalid, s_rlast;
  logic [1:0][DW-1:0] s_rdata;
  logic [1:0][1:0]    s_rresp;
  logic [AW-1:0]      m_araddr;
  logic [7:0]         m_arlen;
  logic               m_arvalid, m_rready;
  logic               m_arready = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0;
  logic [DW-1:0]      m_rdata = '0;
  logic [1:0]         m_rresp = '0;

  sda_gmem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(rst),
    .s0_araddr(s_araddr[0]), .s0_arlen(s_arlen[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
    .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rlast(s_rlast[0]), .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
    .s1_araddr(s_araddr[1]), .s1_arlen(s_arlen[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
    .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rlast(s_rlast[1]), .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  typedef struct {logic [AW-1:0] addr; logic [7:0] len;} req_t;
  typedef struct {int id; logic [AW-1:0] addr; logic [7:0] len;} ar_t;
  typedef struct {logic [DW-1:0] data; logic last; logic [1:0] resp;} r_t;

  req_t req_q[2][$];
  req_t gm_q[$];
  ar_t  ar_exp[$];
  int   rt_q[$];
  r_t   exp_r[2][$];
  int   gnt_log[$];

  int total = 0, bad = 0;
  bit pend = 0;
  int prio = 0;
  int ar_hs_cnt = 0;
  bit [1:0] s_fire = '0;
  bit r_fire = 0, r_fire_last = 0, rst_prev = 0;
  int r_allow = 1000000;
  bit r_rand = 0, rr_rand = 0, gap_rand = 0, force_rv = 0;
  int ar_mode = 1;
  int gm_beat = 0;

  function automatic logic [DW-1:0] beat_data(logic [AW-1:0] a, int b);
    return {a[31:0] ^ 32'h5A5A_0F0F, a[47:32], 8'h00, 8'(b)};
  endfunction
  function automatic logic [1:0] beat_resp(logic [AW-1:0] a, int b);
    return (a[4] && b == 0) ? 2'b10 : 2'b00;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / reference model: checks first, then updates for the coming edge.
  always @(negedge clk) begin
    ar_t e;
    r_t  r;
    bit  er;
    s_fire = '0; r_fire = 0; r_fire_last = 0;
    if (rst) begin
      if (rst_prev) begin
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_m_araddr", m_araddr, 0);
        chk("rst_m_arlen", m_arlen, 0);
      end
      ar_exp.delete(); rt_q.delete(); exp_r[0].delete(); exp_r[1].delete();
      pend = 0; prio = 0;
    end else begin
      chk("m_arvalid", m_arvalid, pend);
      if (pend && ar_exp.size() > 0) begin
        chk("m_araddr", m_araddr, ar_exp[0].addr);
        chk("m_arlen", m_arlen, ar_exp[0].len);
      end
      for (int i = 0; i < 2; i++) begin
        er = !pend && rt_q.size() < MAX && s_arvalid[i] && (prio == i || !s_arvalid[prio]);
        chk($sformatf("s%0d_arready", i), s_arready[i], er);
        er = rt_q.size() > 0 && rt_q[0] == i && m_rvalid;
        chk($sformatf("s%0d_rvalid", i), s_rvalid[i], er);
      end
      chk("m_rready", m_rready, rt_q.size() > 0 ? s_rready[rt_q[0]] : 1'b0);
      for (int i = 0; i < 2; i++) begin
        if (s_rvalid[i] && s_rready[i]) begin
          if (exp_r[i].size() == 0) chk($sformatf("s%0d_r_unexpected", i), s_rvalid[i], 0);
          else begin
            r = exp_r[i].pop_front();
            chk($sformatf("s%0d_rdata", i), s_rdata[i], r.data);
            chk($sformatf("s%0d_rlast", i), s_rlast[i], r.last);
            chk($sformatf("s%0d_rresp", i), s_rresp[i], r.resp);
          end
        end
      end
      if (m_arvalid && m_arready) begin
        if (ar_exp.size() > 0) begin
          e = ar_exp.pop_front();
          rt_q.push_back(e.id);
          prio = 1 - e.id;
        end
        pend = 0;
        gm_q.push_back('{m_araddr, m_arlen});
        ar_hs_cnt++;
      end
      for (int i = 0; i < 2; i++) begin
        if (s_arvalid[i] && s_arready[i] && req_q[i].size() > 0) begin
          e.id = i; e.addr = req_q[i][0].addr; e.len = req_q[i][0].len;
          ar_exp.push_back(e);
          gnt_log.push_back(i);
          pend = 1; s_fire[i] = 1;
          for (int b = 0; b <= int'(e.len); b++) begin
            r.data = beat_data(e.addr, b);
            r.last = (b == int'(e.len));
            r.resp = beat_resp(e.addr, b);
            exp_r[i].push_back(r);
          end
        end
      end
      if (m_rvalid && m_rready) begin
        r_fire = 1; r_fire_last = m_rlast;
        if (m_rlast && rt_q.size() > 0) void'(rt_q.pop_front());
      end
    end
    rst_prev = rst;
  end

  // Requester and gmem drivers.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      gm_q.delete(); gm_beat = 0;
      m_rvalid = 0; m_rlast = 0;
      s_arvalid = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s_fire[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
        if (!(s_arvalid[i] && !s_fire[i])) begin
          if (req_q[i].size() > 0 && (!gap_rand || $urandom_range(0, 2) == 0)) begin
            s_arvalid[i] = 1; s_araddr[i] = req_q[i][0].addr; s_arlen[i] = req_q[i][0].len;
          end else s_arvalid[i] = 0;
        end
        s_rready[i] = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      m_arready = (ar_mode == 2) ? 1'($urandom_range(0, 1)) : (ar_mode == 1);
      if (r_fire && gm_q.size() > 0) begin
        if (r_fire_last) begin
          void'(gm_q.pop_front()); gm_beat = 0;
          if (r_allow > 0) r_allow--;
        end else gm_beat++;
        m_rvalid = 0;
      end
      if (force_rv) begin
        m_rvalid = 1; m_rdata = '1; m_rlast = 1; m_rresp = 2'b00;
      end else if (gm_q.size() == 0) m_rvalid = 0;
      else if (!m_rvalid && r_allow > 0 && (!r_rand || $urandom_range(0, 2) != 0)) begin
        m_rvalid = 1;
        m_rdata  = beat_data(gm_q[0].addr, gm_beat);
        m_rlast  = (gm_beat == int'(gm_q[0].len));
        m_rresp  = beat_resp(gm_q[0].addr, gm_beat);
      end
    end
  end

  task automatic wait_drain(string name, int bound);
    int n = 0;
    while (n < bound && (req_q[0].size() + req_q[1].size() + ar_exp.size() + rt_q.size()
                         + exp_r[0].size() + exp_r[1].size()) != 0) begin
      @(posedge clk); n++;
    end
    chk(name, req_q[0].size() + req_q[1].size() + ar_exp.size() + rt_q.size()
              + exp_r[0].size() + exp_r[1].size(), 0);
  endtask

  task automatic push_req(int i, logic [AW-1:0] a, logic [7:0] l);
    req_t q;
    q.addr = a; q.len = l;
    req_q[i].push_back(q);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // single request
    push_req(0, 64'h1000, 8'd3);
    wait_drain("drain_single", 100);

    // contention, differing burst lengths
    gnt_log.delete();
    for (int k = 0; k < 4; k++) begin
      push_req(0, 64'h2000 + 64'(k * 64), 8'd0);
      push_req(1, 64'h3010 + 64'(k * 64), 8'd7);
    end
    wait_drain("drain_contention", 300);
    chk("contention_grants", gnt_log.size(), 8);
    for (int j = 1; j < gnt_log.size(); j++) chk("grant_alternates", gnt_log[j] != gnt_log[j-1], 1);

    // AR backpressure, then R backpressure
    ar_mode = 0;
    push_req(1, 64'h4000, 8'd5);
    repeat (7) @(posedge clk);
    #3 chk("bp_m_arvalid_held", m_arvalid, 1);
    chk("bp_m_araddr_held", m_araddr, 64'h4000);
    ar_mode = 1; rr_rand = 1;
    wait_drain("drain_backpressure", 200);

    // FIFO full
    rr_rand = 0; r_allow = 0; ar_hs_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      push_req(0, 64'h5000 + 64'(k * 64), 8'd2);
      push_req(1, 64'h6000 + 64'(k * 64), 8'd2);
    end
    repeat (20) @(posedge clk);
    chk("full_handshakes", ar_hs_cnt, 4);
    r_allow = 1;
    repeat (30) @(posedge clk);
    chk("full_one_more_grant", ar_hs_cnt, 5);
    r_allow = 1000000;
    wait_drain("drain_full", 400);

    // randomized traffic
    gap_rand = 1; rr_rand = 1; r_rand = 1; ar_mode = 2;
    for (int k = 0; k < 30; k++) begin
      push_req(0, {$urandom, $urandom}, 8'($urandom_range(0, 7)));
      push_req(1, {$urandom, $urandom}, 8'($urandom_range(0, 7)));
    end
    wait_drain("drain_random", 4000);

    // reset with three bursts outstanding, mid-burst
    gap_rand = 0; rr_rand = 0; r_rand = 0; ar_mode = 1;
    for (int k = 0; k < 3; k++) push_req(0, 64'h7000 + 64'(k * 64), 8'd7);
    for (int k = 0; k < 2; k++) push_req(1, 64'h8000 + 64'(k * 64), 8'd7);
    n = 0;
    while (n < 60 && !(rt_q.size() >= 3 && prio == 1)) begin @(posedge clk); n++; end
    chk("reset_setup_outstanding", rt_q.size() >= 3, 1);
    @(posedge clk);
    #1 rst = 1;
    req_q[0].delete(); req_q[1].delete();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    force_rv = 1;
    repeat (3) @(posedge clk);
    force_rv = 0;
    repeat (2) @(posedge clk);
    gnt_log.delete();
    push_req(0, 64'h9000, 8'd1);
    push_req(1, 64'h9800, 8'd1);
    wait_drain("drain_after_reset_both", 100);
    push_req(1, 64'hA000, 8'd2);
    wait_drain("drain_after_reset_s1", 100);
    chk("post_reset_grants", gnt_log.size(), 3);
    if (gnt_log.size() == 3) begin
      chk("post_reset_first_grant", gnt_log[0], 0);
      chk("post_reset_s1_alone", gnt_log[2], 1);
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sda_gmem_read_arbiter.md
Name: sda_gmem_read_arbiter

Overview:
- Shares the single kernel global-memory AXI4 read channel (AR + R) between two action-side read requesters.
- Sits between the generated action core's read ports and the gmem master port of the kernel wrapper, in the kernel clock domain.
- Arbitrates AR bursts round-robin and records each grant in a route FIFO. Uses that FIFO to steer in-order R beats back to the owning requester, because the gmem ID is not used for routing.

Parameters:
- ADDR_WIDTH, 64, read address width on all ports
- DATA_WIDTH, 64, read data width on all ports
- MAX_OUTSTANDING, 4, route FIFO depth; maximum number of bursts accepted by gmem whose RLAST has not yet returned (power of two, ≥2)

Ports:
- clk  in  1  kernel clock
- reset  in  1  synchronous active-high reset
- s0_araddr  in  ADDR_WIDTH  requester 0 burst address
- s0_arlen  in  8  requester 0 burst length-1
- s0_arvalid  in  1  requester 0 address valid
- s0_arready  out  1  requester 0 address accepted
- s0_rdata  out  DATA_WIDTH  read data to requester 0
- s0_rresp  out  2  read response to requester 0
- s0_rlast  out  1  last beat to requester 0
- s0_rvalid  out  1  beat valid to requester 0
- s0_rready  in  1  requester 0 beat ready
- s1_*  same nine signals as s0_*, for requester 1
- m_araddr  out  ADDR_WIDTH  gmem burst address
- m_arlen  out  8  gmem burst length-1
- m_arvalid  out  1  gmem address valid
- m_arready  in  1  gmem address ready
- m_rdata  in  DATA_WIDTH  gmem read data
- m_rresp  in  2  gmem read response
- m_rlast  in  1  gmem last beat
- m_rvalid  in  1  gmem beat valid
- m_rready  out  1  gmem beat ready

Behaviour:

Reset (synchronous, active-high):
- m_arvalid=0; s0_arready=0; s1_arready=0; s0_rvalid=0; s1_rvalid=0; m_rready=0.
- m_araddr=0; m_arlen=0.
- Route FIFO empty (count=0, pointers=0); round-robin priority pointer=0; FSM in IDLE.
- A reset asserted mid-burst discards all outstanding routing state. The gmem side is reset together with this block (kernel reset), so no recovery is attempted.

AR FSM, two states:
- IDLE:
  - s0_arready/s1_arready are combinational.
  - The selected requester's arready is 1 iff its arvalid=1 AND FIFO count < MAX_OUTSTANDING (count-only check; simultaneous pop is not credited) AND it wins arbitration.
  - Winner: the requester at the priority pointer if it is valid, otherwise the other requester.
  - On grant: latch araddr/arlen into m_araddr/m_arlen; latch the grant index; go to ISSUE.
  - At most one arready is high per cycle.
- ISSUE:
  - m_arvalid=1; m_araddr/m_arlen held stable.
  - Both s*_arready=0.
  - On m_arready=1: push the grant index into the route FIFO; set priority pointer to the other requester; m_arvalid drops next cycle; return to IDLE.
- Throughput: maximum one burst per 2 cycles. Latency: requester handshake to m_arvalid = 1 cycle.

R routing, combinational from the FIFO head:
- FIFO empty: m_rready=0; s0_rvalid=0; s1_rvalid=0.
- FIFO non-empty, head=h:
  - sh_rvalid=m_rvalid; the other requester's rvalid=0.
  - m_rready=sh_rready.
- m_rdata/m_rresp/m_rlast are broadcast to both s*_rdata/rresp/rlast; only rvalid qualifies them.
- Pop the FIFO on a beat with m_rvalid & m_rready & m_rlast. Non-last beats never pop.
- RRESP errors are passed through unchanged; they have no effect on routing.

Route FIFO:
- Circular buffer; read/write pointers wrap modulo MAX_OUTSTANDING.
- Push and pop in the same cycle leave count unchanged.
- Full (count=MAX_OUTSTANDING) blocks new grants; it does not affect an AR already in ISSUE.
- Push only happens from ISSUE, which required count<MAX at grant time. A push therefore never occurs when full.

Boundary conditions:
- Both requesters valid continuously: grants alternate 0,1,0,1.
- m_rvalid while the FIFO is empty is a protocol violation. It stalls with m_rready=0 and is not dropped.
- A requester holding rready=0 stalls the gmem R channel. No reordering is performed.

Test Plan:
- Single request: s0 arvalid, araddr=0x1000, arlen=3, m_arready tied 1.
  - Required: s0_arready pulses in cycle 0; m_arvalid high in cycle 1 with araddr 0x1000, arlen 3.
  - Four R beats (last on beat 4) reach s0 only; FIFO count returns to 0.
- Contention: both requesters valid continuously for 4 bursts each.
  - Required: AR grant order 0,1,0,1,...; R bursts of differing arlen (0 and 7) are routed in grant order, never to the wrong requester.
- FIFO full: MAX_OUTSTANDING=4, gmem accepts AR but withholds R.
  - Required: exactly 4 m_arvalid handshakes, then both s*_arready stay 0.
  - After one RLAST pops, exactly one further grant occurs.
- Backpressure: m_arready low for 5 cycles during ISSUE.
  - Required: m_araddr/m_arlen stable and m_arvalid held; no s*_arready asserted.
  - s1_rready=0 mid-burst → m_rready=0 and the beat is held, resuming when s1_rready=1.
- Simultaneous push/pop: an AR handshake in the same cycle as an RLAST beat with count=2.
  - Required: count stays 2 and the head advances correctly.
- Reset mid-operation: assert reset with 3 bursts outstanding, partway through a burst.
  - Required: next cycle all valid/ready outputs are 0 and the FIFO is empty.
  - The next s1 request is granted first, since the priority pointer resets to 0 and s0 is idle.
